// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: PCSrc encodings,
// IF/ID register operations and address helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'b00,
        IFID_LOAD   = 2'b01,
        IFID_BUBBLE = 2'b10
    } if_id_op_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_stage_if;
    logic [31:0] ImemAddr;
    logic [31:0] ImemData;
    logic        ImemValid;

    modport master (output ImemAddr, input ImemData, input ImemValid);
    modport slave  (input ImemAddr, output ImemData, output ImemValid);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: holds, loads a fetched instruction, or loads a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  if_id_op_e   op,
    input  logic [31:0] instr_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] Instruction,
    output logic [31:0] PCPlus4,
    output logic        Valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    // Next-state selection for the pipeline register.
    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        case (op)
            IFID_LOAD: begin
                instr_d   = instr_in;
                pcplus4_d = pcplus4_in;
                valid_d   = 1'b1;
            end
            IFID_BUBBLE: begin
                instr_d   = NOP_INSTR;
                pcplus4_d = 32'h0000_0000;
                valid_d   = 1'b0;
            end
            IFID_HOLD: begin
                instr_d   = instr_q;
                pcplus4_d = pcplus4_q;
                valid_d   = valid_q;
            end
            default: begin
                instr_d   = NOP_INSTR;
                pcplus4_d = 32'h0000_0000;
                valid_d   = 1'b0;
            end
        endcase
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign Instruction = instr_q;
    assign PCPlus4     = pcplus4_q;
    assign Valid       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Optional build macro FETCH_ALIGN_CHECK_EN enables the sticky AlignErr flag.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrTarget,
    fetch_stage_if.master imem,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        AlignErr
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;
    logic        redirect_s;
    pcsrc_e      pcsrc_s;
    if_id_op_e   if_id_op_s;

    assign pcsrc_s    = pcsrc_e'(PCSrc);
    assign pc_plus4_s = pc_q + PC_STEP;
    assign redirect_s = (pcsrc_s != PCSRC_SEQ);

    // Redirect target mux; jumps take their upper bits from the instruction in IF/ID.
    always_comb begin
        target_s = pc_plus4_s;
        case (pcsrc_s)
            PCSRC_SEQ: target_s = pc_plus4_s;
            PCSRC_BR:  target_s = BranchTarget;
            PCSRC_J:   target_s = {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00};
            PCSRC_JR:  target_s = JrTarget;
            default:   target_s = pc_plus4_s;
        endcase
    end

    // Priority: redirect, then stall, then missing memory data, then normal fetch.
    always_comb begin
        pc_d       = pc_q;
        if_id_op_s = IFID_HOLD;
        if (redirect_s) begin
            pc_d       = word_align(target_s);
            if_id_op_s = IFID_BUBBLE;
        end else if (Stall) begin
            pc_d       = pc_q;
            if_id_op_s = IFID_HOLD;
        end else if (!imem.ImemValid) begin
            pc_d       = pc_q;
            if_id_op_s = IFID_BUBBLE;
        end else begin
            pc_d       = word_align(pc_plus4_s);
            if_id_op_s = IFID_LOAD;
        end
    end

    // PC register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .Clk        (Clk),
        .Reset      (Reset),
        .op         (if_id_op_s),
        .instr_in   (imem.ImemData),
        .pcplus4_in (pc_plus4_s),
        .Instruction(IF_ID_Instruction),
        .PCPlus4    (IF_ID_PCPlus4),
        .Valid      (IF_ID_Valid)
    );

    assign imem.ImemAddr = pc_q;
    assign PC            = pc_q;
    assign Opcode        = IF_ID_Instruction[31:26];
    assign Funct         = IF_ID_Instruction[5:0];

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q, align_err_d;

    // Only register-sourced targets can be misaligned; jumps are aligned by construction.
    always_comb begin
        align_err_d = align_err_q;
        if (redirect_s && ((pcsrc_s == PCSRC_BR) || (pcsrc_s == PCSRC_JR)) &&
            is_misaligned(target_s)) begin
            align_err_d = 1'b1;
        end else begin
            align_err_d = align_err_q;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= align_err_d;
        end
    end

    assign AlignErr = align_err_q;
`else
    assign AlignErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random traffic,
// checked against a transaction-level model of the fetch rules.
module tb_fetch_stage;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        err;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;
    logic [31:0] JrTarget;
    logic        imem_valid;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic        AlignErr;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];
    exp_t m;

    fetch_stage_if bus ();

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
    endfunction

    assign bus.ImemData  = mem_word(bus.ImemAddr);
    assign bus.ImemValid = imem_valid;

    fetch_stage dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .PCSrc            (PCSrc),
        .BranchTarget     (BranchTarget),
        .JumpIndex        (JumpIndex),
        .JrTarget         (JrTarget),
        .imem             (bus),
        .PC               (PC),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .Opcode           (Opcode),
        .Funct            (Funct),
        .AlignErr         (AlignErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: apply one clock edge of the fetch rules to model state m.
    task automatic model_edge();
        logic [31:0] tgt;
        if (!Reset) begin
            m = '0;
        end else if (PCSrc != 2'b00) begin
            case (PCSrc)
                2'b01:   tgt = BranchTarget;
                2'b10:   tgt = {m.pc4[31:28], JumpIndex, 2'b00};
                default: tgt = JrTarget;
            endcase
            if (ALIGN_EN && (PCSrc != 2'b10) && (tgt % 4 != 0)) m.err = 1'b1;
            m.pc    = tgt - (tgt % 4);
            m.instr = 32'h0;
            m.pc4   = 32'h0;
            m.valid = 1'b0;
        end else if (Stall) begin
            m = m;
        end else if (!imem_valid) begin
            m.instr = 32'h0;
            m.pc4   = 32'h0;
            m.valid = 1'b0;
        end else begin
            m.instr = mem_word(m.pc);
            m.pc4   = m.pc + 32'd4;
            m.valid = 1'b1;
            m.pc    = m.pc + 32'd4;
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic [1:0] src,
                        input logic [31:0] bt, input logic [25:0] ji,
                        input logic [31:0] jr, input logic iv);
        @(negedge Clk);
        Reset        = rst;
        Stall        = st;
        PCSrc        = src;
        BranchTarget = bt;
        JumpIndex    = ji;
        JrTarget     = jr;
        imem_valid   = iv;
        model_edge();
        exp_q.push_back(m);
    endtask

    task automatic nrm();
        step(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b1);
    endtask

    // Monitor: compare every post-edge output against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",       PC,                e.pc);
                check("imemaddr", bus.ImemAddr,      e.pc);
                check("instr",    IF_ID_Instruction, e.instr);
                check("pcplus4",  IF_ID_PCPlus4,     e.pc4);
                check("valid",    {31'h0, IF_ID_Valid}, {31'h0, e.valid});
                check("opcode",   {26'h0, Opcode},   {26'h0, e.instr[31:26]});
                check("funct",    {26'h0, Funct},    {26'h0, e.instr[5:0]});
                check("alignerr", {31'h0, AlignErr}, {31'h0, e.err});
            end
        end
    end

    initial begin
        logic [1:0] src;
        int drain;
        m            = '0;
        Reset        = 1'b0;
        Stall        = 1'b0;
        PCSrc        = 2'b00;
        BranchTarget = 32'h0;
        JumpIndex    = 26'h0;
        JrTarget     = 32'h0;
        imem_valid   = 1'b1;

        // Reset, release, sequential fetch from 0.
        step(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b1);
        nrm(); nrm();
        // Stall three cycles at PC=8, then resume.
        repeat (3) step(1'b1, 1'b1, 2'b00, 32'h0, 26'h0, 32'h0, 1'b1);
        nrm();
        // Branch together with stall.
        step(1'b1, 1'b1, 2'b01, 32'h0000_0040, 26'h0, 32'h0, 1'b1);
        nrm(); nrm();
        // Jump using IF_ID_PCPlus4 upper bits, then misaligned jr.
        step(1'b1, 1'b0, 2'b11, 32'h0, 26'h0, 32'h1000_000C, 1'b1);
        nrm();
        step(1'b1, 1'b0, 2'b10, 32'h0, 26'h000_0100, 32'h0, 1'b1);
        step(1'b1, 1'b0, 2'b11, 32'h0, 26'h0, 32'h0000_0022, 1'b1);
        // Back-to-back redirects, then memory not ready at 0x10.
        step(1'b1, 1'b0, 2'b01, 32'h0000_0010, 26'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0, 1'b0);
        nrm();
        // PC wrap from 0xFFFF_FFFC.
        step(1'b1, 1'b0, 2'b11, 32'h0, 26'h0, 32'hFFFF_FFFC, 1'b1);
        nrm(); nrm();
        // Reset mid-run overrides stall and redirect.
        step(1'b0, 1'b1, 2'b01, 32'h0000_0081, 26'h0, 32'h0, 1'b1);
        nrm(); nrm();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            src = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 4) == 0),
                 src,
                 $urandom,
                 26'($urandom),
                 $urandom,
                 ($urandom_range(0, 4) != 0));
        end

        drain = 0;
        while ((exp_q.size() > 0) && (drain < 10)) begin
            @(posedge Clk);
            #2;
            drain++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
